// File: rtl/ysyx_25040129_rd_arbiter.sv
// Two-to-one AXI4 read-channel arbiter (IFU bursts, LSU single beats) with a single outstanding transaction.
// Tie-break policy: fixed LSU priority by default; define YSYX_25040129_ARB_RR_EN for round-robin.
module ysyx_25040129_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic [LEN_W-1:0]  ifu_arlen,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic [LEN_W-1:0]  mem_arlen,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [31:0]       mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rlast
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              ifu_win;
    logic              lsu_win;
    logic              idle;

`ifdef YSYX_25040129_ARB_RR_EN
    logic last_q, last_d;
    // On a tie the requester that was not served last takes the grant.
    assign ifu_win = ifu_arvalid && (!lsu_arvalid || (last_q == OWN_LSU));
`else
    assign ifu_win = ifu_arvalid && !lsu_arvalid;
`endif
    assign lsu_win = lsu_arvalid && !ifu_win;

    assign idle        = (state_q == IDLE) && !reset;
    assign ifu_arready = idle && ifu_win;
    assign lsu_arready = idle && lsu_win;

    assign mem_arvalid = (state_q == ADDR);
    assign mem_araddr  = addr_q;
    assign mem_arlen   = len_q;

    // Beats flow straight through; only the owner ever sees rvalid or drives rready.
    assign ifu_rvalid = (state_q == DATA) && (owner_q == OWN_IFU) && mem_rvalid;
    assign lsu_rvalid = (state_q == DATA) && (owner_q == OWN_LSU) && mem_rvalid;
    assign mem_rready = (state_q == DATA) && ((owner_q == OWN_LSU) ? lsu_rready : ifu_rready);

    // Data and response wires reach the requesters directly at the parent level.
    logic unused_rdata;
    assign unused_rdata = ^{mem_rdata, mem_rresp};

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (ifu_win) begin
                    state_d = ADDR;
                    owner_d = OWN_IFU;
                    addr_d  = ifu_araddr;
                    len_d   = ifu_arlen;
                end else if (lsu_win) begin
                    state_d = ADDR;
                    owner_d = OWN_LSU;
                    addr_d  = lsu_araddr;
                    len_d   = '0;
                end
            end
            ADDR: begin
                if (mem_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (mem_rvalid && mem_rready && mem_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef YSYX_25040129_ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if ((state_q == IDLE) && (ifu_win || lsu_win)) begin
            last_d = owner_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= OWN_LSU;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_rd_arbiter.sv
// Directed bench for ysyx_25040129_rd_arbiter; expectations follow YSYX_25040129_ARB_RR_EN when defined.
module tb_ysyx_25040129_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_arvalid, ifu_arready;
    logic [31:0] ifu_araddr;
    logic [7:0]  ifu_arlen;
    logic        ifu_rvalid, ifu_rready;
    logic        lsu_arvalid, lsu_arready;
    logic [31:0] lsu_araddr;
    logic        lsu_rvalid, lsu_rready;
    logic        mem_arvalid, mem_arready;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic        mem_rvalid, mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rlast;

    int n_vec = 0;
    int n_err = 0;
    int mem_hs = 0;
    int ifu_hs = 0;
    int base_mem;
    int base_ifu;
    bit first_lsu;
    bit w;

    always #5 clock = ~clock;

    ysyx_25040129_rd_arbiter #(.ADDR_W(32), .LEN_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .ifu_arvalid (ifu_arvalid),
        .ifu_arready (ifu_arready),
        .ifu_araddr  (ifu_araddr),
        .ifu_arlen   (ifu_arlen),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rready  (ifu_rready),
        .lsu_arvalid (lsu_arvalid),
        .lsu_arready (lsu_arready),
        .lsu_araddr  (lsu_araddr),
        .lsu_rvalid  (lsu_rvalid),
        .lsu_rready  (lsu_rready),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rlast   (mem_rlast)
    );

    // Handshake counters used to detect lost or duplicated beats.
    always @(posedge clock) begin
        if (mem_rvalid && mem_rready) mem_hs <= mem_hs + 1;
        if (ifu_rvalid && ifu_rready) ifu_hs <= ifu_hs + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // A lone LSU probe must see arready at once only when the block is idle.
    task automatic probe_idle(input string tag);
        lsu_arvalid = 1'b1;
        settle();
        chk(tag, 64'({mem_arvalid, lsu_arready}), 64'd1);
        lsu_arvalid = 1'b0;
        settle();
    endtask

    // Caller has raised the request(s); checks grant, address phase and every beat of the winner.
    task automatic grant_and_run(input bit is_lsu, input logic [31:0] a, input logic [7:0] l,
                                 input logic [1:0] resp);
        settle();
        chk("arready_grant", 64'({ifu_arready, lsu_arready}), is_lsu ? 64'd1 : 64'd2);
        tick();
        if (is_lsu) lsu_arvalid = 1'b0;
        else        ifu_arvalid = 1'b0;
        mem_rvalid = 1'b1;
        ifu_rready = 1'b1;
        lsu_rready = 1'b1;
        settle();
        chk("addr_phase", 64'({mem_arvalid, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, mem_rready}),
            64'b100000);
        chk("araddr", 64'(mem_araddr), 64'(a));
        chk("arlen", 64'(mem_arlen), 64'(l));
        mem_rvalid  = 1'b0;
        mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            mem_rvalid = 1'b1;
            mem_rlast  = (i == int'(l));
            mem_rresp  = resp;
            mem_rdata  = a + 32'(i * 4);
            settle();
            chk("beat_route", 64'({ifu_rvalid, lsu_rvalid, mem_rready, ifu_arready, lsu_arready}),
                is_lsu ? 64'b01100 : 64'b10100);
            tick();
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        mem_rresp  = 2'b00;
        ifu_rready = 1'b0;
        lsu_rready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_arlen = '0; ifu_rready = 1'b0;
        lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_rready = 1'b0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0; mem_rlast = 1'b0;
`ifdef YSYX_25040129_ARB_RR_EN
        first_lsu = 1'b0;
`else
        first_lsu = 1'b1;
`endif

        // Reset state
        do_reset();
        settle();
        chk("rst_handshakes", 64'({mem_arvalid, mem_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid}), 64'd0);
        chk("rst_araddr", 64'(mem_araddr), 64'd0);
        chk("rst_arlen", 64'(mem_arlen), 64'd0);

        // IFU-only 4-beat burst
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_arlen = 8'd3;
        base_mem = mem_hs;
        grant_and_run(1'b0, 32'h3000_0000, 8'd3, 2'b00);
        chk("ifu_burst_beats", 64'(mem_hs - base_mem), 64'd4);
        probe_idle("idle_after_burst");

        // Simultaneous requests
        do_reset();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0010; ifu_arlen = 8'd1;
        lsu_arvalid = 1'b1; lsu_araddr = 32'ha000_0000;
        grant_and_run(first_lsu, first_lsu ? 32'ha000_0000 : 32'h3000_0010, first_lsu ? 8'd0 : 8'd1, 2'b00);
        grant_and_run(!first_lsu, first_lsu ? 32'h3000_0010 : 32'ha000_0000, first_lsu ? 8'd1 : 8'd0, 2'b00);
        probe_idle("idle_after_tie");

        // Backpressure on address and data channels
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0020; ifu_arlen = 8'd2;
        settle();
        chk("bp_grant", 64'(ifu_arready), 64'd1);
        tick();
        ifu_arvalid = 1'b0; ifu_araddr = 32'hdead_beef; ifu_arlen = 8'hff;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_ar_stable", 64'({mem_arvalid, mem_arlen, mem_araddr}), {23'd0, 1'b1, 8'd2, 32'h3000_0020});
            tick();
        end
        mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0;
        base_mem = mem_hs;
        base_ifu = ifu_hs;
        mem_rvalid = 1'b1; mem_rlast = 1'b0; ifu_rready = 1'b1;
        settle();
        chk("bp_beat1", 64'({ifu_rvalid, mem_rready}), 64'b11);
        tick();
        ifu_rready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("bp_stall", 64'({ifu_rvalid, mem_rready}), 64'b10);
            tick();
        end
        ifu_rready = 1'b1;
        settle();
        chk("bp_beat2", 64'({ifu_rvalid, mem_rready}), 64'b11);
        tick();
        mem_rlast = 1'b1;
        settle();
        chk("bp_beat3", 64'({ifu_rvalid, mem_rready}), 64'b11);
        tick();
        mem_rvalid = 1'b0; mem_rlast = 1'b0; ifu_rready = 1'b0;
        chk("bp_mem_beats", 64'(mem_hs - base_mem), 64'd3);
        chk("bp_ifu_beats", 64'(ifu_hs - base_ifu), 64'd3);
        probe_idle("idle_after_bp");

        // Error response on an LSU load
        lsu_arvalid = 1'b1; lsu_araddr = 32'ha000_0004;
        grant_and_run(1'b1, 32'ha000_0004, 8'd0, 2'b10);
        probe_idle("idle_after_err");

        // Reset during beat 2 of an 8-beat IFU burst
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0040; ifu_arlen = 8'd7;
        settle();
        tick();
        ifu_arvalid = 1'b0;
        mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0;
        mem_rvalid = 1'b1; ifu_rready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rst_mid_handshakes", 64'({mem_arvalid, mem_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid}), 64'd0);
        chk("rst_mid_addr", 64'({mem_arlen, mem_araddr}), 64'd0);
        mem_rvalid = 1'b0; ifu_rready = 1'b0;
        lsu_arvalid = 1'b1; lsu_araddr = 32'ha000_0008;
        grant_and_run(1'b1, 32'ha000_0008, 8'd0, 2'b00);

        // Both requesters continuously pending for six single-beat grants
        do_reset();
        ifu_araddr = 32'h3000_0100; ifu_arlen = 8'd0; lsu_araddr = 32'ha000_0100;
        for (int k = 0; k < 6; k++) begin
            ifu_arvalid = 1'b1;
            lsu_arvalid = 1'b1;
`ifdef YSYX_25040129_ARB_RR_EN
            w = (k % 2 == 1);
`else
            w = 1'b1;
`endif
            grant_and_run(w, w ? 32'ha000_0100 : 32'h3000_0100, 8'd0, 2'b00);
        end
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_25040129_rd_arbiter.md
# ysyx_25040129_rd_arbiter

Two-to-one AXI4 read-channel arbiter that shares the core's single master read port between the instruction fetch unit (IFU, burst reads) and the load/store unit (LSU, single-beat loads). It sits inside `ysyx_25040129`, between the IFU/LSU read interfaces and the `io_master_ar*`/`io_master_r*` pins. It grants one requester at a time and holds the grant until that requester's last read beat has been transferred. The write channels bypass this block.

## Interface
- ADDR_W, 32, address width of all `araddr` ports
- LEN_W, 8, burst length width (AXI4 `arlen`; beats = len+1)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ifu_arvalid  in  1  IFU read request
- ifu_arready  out  1  IFU request accepted
- ifu_araddr  in  ADDR_W  IFU start address
- ifu_arlen  in  LEN_W  IFU burst length
- ifu_rvalid  out  1  read beat valid for IFU
- ifu_rready  in  1  IFU accepts beat
- lsu_arvalid  in  1  LSU read request (single beat, len fixed 0)
- lsu_arready  out  1  LSU request accepted
- lsu_araddr  in  ADDR_W  LSU address
- lsu_rvalid  out  1  read beat valid for LSU
- lsu_rready  in  1  LSU accepts beat
- mem_arvalid  out  1  downstream request valid
- mem_arready  in  1  downstream request accepted
- mem_araddr  out  ADDR_W  latched address of the granted request
- mem_arlen  out  LEN_W  latched length of the granted request (0 for LSU)
- mem_rvalid  in  1  downstream beat valid
- mem_rready  out  1  routed from the granted requester
- mem_rdata  in  32  read data; fanned out unregistered to both requesters
- mem_rresp  in  2  response; fanned out unregistered to both requesters
- mem_rlast  in  1  last beat; fanned out unregistered to both requesters

## Operation
- State machine with three states:
  - IDLE: no grant held.
  - ADDR: `mem_arvalid`=1, waiting for `mem_arready`.
  - DATA: forwarding read beats to the owner.
- IDLE → ADDR:
  - Taken when either `*_arvalid` is high.
  - The winner's `*_arready` is driven high combinationally in the same cycle. The loser's `*_arready` stays 0.
  - In that cycle, latch the winner's address and length (LSU length forced to 0) and the owner ID.
- Arbitration:
  - Only one request pending: that request wins.
  - Both pending: the tie is broken per Configuration.
- ADDR → DATA on `mem_arvalid && mem_arready`. `mem_araddr` and `mem_arlen` stay stable while `mem_arvalid` is high.
- DATA:
  - Owner signals: `owner_rvalid = mem_rvalid` and `mem_rready = owner_rready`.
  - Non-owner `*_rvalid` is 0.
  - DATA → IDLE on `mem_rvalid && mem_rready && mem_rlast`.
- `mem_rresp` is passed through unchanged. Error beats do not abort the burst; only `mem_rlast` ends the grant.
- A requester dropping `arvalid` before its `arready` is a protocol violation; behaviour is unspecified.
- Reset values:
  - State IDLE.
  - All valid/ready outputs 0.
  - `mem_araddr` and `mem_arlen` 0.
  - Last-served register = LSU.
- Reset mid-burst: return to IDLE next cycle. Remaining downstream beats are dropped, because `mem_rready`=0 until a new grant.

## Timing
- Request accepted in cycle N (IDLE): `mem_arvalid` is high at N+1.
- With `mem_arready` high at N+1, the first beat can be forwarded at N+2. Data is not registered; there is zero extra latency per beat.
- After the last-beat handshake at cycle M, the block is in IDLE at M+1, and a new request can be accepted at M+1. Back-to-back turnaround is therefore 2 cycles of `mem_arvalid` gap minimum.
- A new request never overlaps an outstanding burst (single outstanding transaction).

## Configuration
- `YSYX_25040129_ARB_RR_EN` defined: round-robin. On a tie, the requester not served last wins, and the last-served register updates on every grant. After reset the IFU wins the first tie.
- `YSYX_25040129_ARB_RR_EN` undefined: fixed priority, LSU always wins ties. The last-served register is unused.

## Test plan
- IFU-only burst:
  - Stimulus: `ifu_araddr`=0x3000_0000, `ifu_arlen`=3; memory returns 4 beats with `rlast` on beat 4.
  - Response: `mem_arlen`=3, `ifu_rvalid` on all 4 beats, `lsu_rvalid`=0 throughout, and IDLE on the cycle after the beat-4 handshake.
- Simultaneous requests, both configurations:
  - Stimulus: same cycle, `ifu_araddr`=0x3000_0010 and `lsu_araddr`=0xa000_0000.
  - RR: IFU granted first, LSU second.
  - Fixed: LSU first, with `mem_arlen`=0.
  - The loser's `arready` stays 0 until the first grant's `rlast` handshake.
- Backpressure:
  - Stimulus: `mem_arready` held low 5 cycles; during DATA, the IFU holds `rready` low for 3 cycles on beat 2.
  - Response: `mem_araddr` and `mem_arlen` stable for those 5 cycles; `mem_rready`=0 while `ifu_rready` is low; no beat lost or duplicated.
- Error response:
  - Stimulus: LSU read whose single beat has `mem_rresp`=2'b10 and `mem_rlast`=1.
  - Response: `lsu_rvalid`=1 with resp 2'b10 visible; grant released.
- Reset mid-burst:
  - Stimulus: assert `reset` during beat 2 of an `arlen`=7 IFU burst.
  - Response: all valid/ready outputs 0 next cycle. A fresh LSU request after reset is granted within 1 cycle.
- RR fairness:
  - Stimulus: both requesters continuously request for 6 grants, each grant single-beat.
  - Response: grants alternate IFU, LSU, IFU, LSU, IFU, LSU.
